// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, condition codes,
// flag bit positions and the fetch-stage FSM encoding.
package wisc_pkg;

   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;
   localparam logic [3:0] OP_PCS = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [2:0] CC_NE = 3'b000;
   localparam logic [2:0] CC_EQ = 3'b001;
   localparam logic [2:0] CC_GT = 3'b010;
   localparam logic [2:0] CC_LT = 3'b011;
   localparam logic [2:0] CC_GE = 3'b100;
   localparam logic [2:0] CC_LE = 3'b101;
   localparam logic [2:0] CC_OV = 3'b110;
   localparam logic [2:0] CC_UN = 3'b111;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } fetch_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: (ccc, {Z,V,N}) -> cond_true.
// Ports: ccc[2:0], flags[2:0] in; cond_true out. Purely combinational.
module branch_cond
   import wisc_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic [2:0] flags,
   output logic       cond_true
);

   logic z;
   logic v;
   logic n;

   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];
   assign n = flags[FLAG_N];

   always_comb begin
      cond_true = 1'b0;
      unique case (ccc)
         CC_NE: cond_true = ~z;
         CC_EQ: cond_true = z;
         CC_GT: cond_true = ~z & ~n;
         CC_LT: cond_true = n;
         CC_GE: cond_true = z | (~z & ~n);
         CC_LE: cond_true = n | z;
         CC_OV: cond_true = v;
         CC_UN: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// WISC PC / flag stage: PC register, {Z,V,N} flags, RUN/HALTED FSM, next-PC mux.
// Ports: clk, rst(sync, high), stall, branch, branch_reg, halt_dec, ccc, imm9,
//   rs_data, alu_flags, flag_we in; pc, pc_plus2, flags, taken, halted out.
module pc_fetch_unit
   import wisc_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branch,
   input  logic            branch_reg,
   input  logic            halt_dec,
   input  logic [2:0]      ccc,
   input  logic [8:0]      imm9,
   input  logic [PC_W-1:0] rs_data,
   input  logic [2:0]      alu_flags,
   input  logic [2:0]      flag_we,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus2,
   output logic [2:0]      flags,
   output logic            taken,
   output logic            halted
);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [2:0]      flags_q;
   logic [2:0]      flags_d;
   logic [PC_W-1:0] offset;
   logic            cond_true;
   logic            adv;

   branch_cond u_cond (
      .ccc       (ccc),
      .flags     (flags_q),
      .cond_true (cond_true)
   );

   // Word offset scaled to bytes; wraps modulo 2^PC_W.
   assign offset   = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};
   assign pc_plus2 = pc_q + {{(PC_W-2){1'b0}}, 2'b10};

   // adv: the stage is allowed to change state this cycle.
   assign adv    = (state_q == ST_RUN) & ~stall;
   // Uses registered flags, so a same-cycle flag write is not seen.
   assign taken  = adv & branch & cond_true;
   assign halted = (state_q == ST_HALTED);
   assign pc     = pc_q;
   assign flags  = flags_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flags_d = flags_q;
      if (adv) begin
         if (halt_dec) begin
            state_d = ST_HALTED;
         end else begin
            flags_d = (flag_we & alu_flags) | (~flag_we & flags_q);
            unique case (1'b1)
               taken & branch_reg:  pc_d = rs_data;
               taken & ~branch_reg: pc_d = pc_plus2 + offset;
               default:             pc_d = pc_plus2;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         flags_q <= 3'b000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then random cycles,
// checked against a behavioural model of PC, flags and halt.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic        branch_reg = 1'b0;
   logic        halt_dec = 1'b0;
   logic [2:0]  ccc = 3'b000;
   logic [8:0]  imm9 = 9'h000;
   logic [15:0] rs_data = 16'h0000;
   logic [2:0]  alu_flags = 3'b000;
   logic [2:0]  flag_we = 3'b000;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic [2:0]  flags;
   logic        taken;
   logic        halted;

   pc_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .branch     (branch),
      .branch_reg (branch_reg),
      .halt_dec   (halt_dec),
      .ccc        (ccc),
      .imm9       (imm9),
      .rs_data    (rs_data),
      .alu_flags  (alu_flags),
      .flag_we    (flag_we),
      .pc         (pc),
      .pc_plus2   (pc_plus2),
      .flags      (flags),
      .taken      (taken),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          chk;
      logic [15:0] pc;
      logic [15:0] pc2;
      logic [2:0]  flags;
      logic        halted;
      logic        taken;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Model state
   bit m_known = 0;
   int m_pc    = 0;
   bit m_z = 0, m_v = 0, m_n = 0;
   bit m_halt  = 0;

   function automatic bit cond(input logic [2:0] c, input bit z, input bit v, input bit n);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic step(input bit r, input bit s, input bit b, input bit br,
                       input bit h, input logic [2:0] c, input logic [8:0] im,
                       input logic [15:0] rs, input logic [2:0] af,
                       input logic [2:0] we);
      exp_t e;
      bit   tk;
      int   off;
      @(negedge clk);
      rst = r; stall = s; branch = b; branch_reg = br; halt_dec = h;
      ccc = c; imm9 = im; rs_data = rs; alu_flags = af; flag_we = we;
      tk = !m_halt && !s && b && cond(c, m_z, m_v, m_n);
      e.chk    = m_known;
      e.pc     = 16'(m_pc);
      e.pc2    = 16'((m_pc + 2) % 65536);
      e.flags  = {m_z, m_v, m_n};
      e.halted = m_halt;
      e.taken  = tk;
      exp_q.push_back(e);
      if (r) begin
         m_known = 1; m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halt = 0;
      end else if (m_halt || s) begin
      end else if (h) begin
         m_halt = 1;
      end else begin
         if (tk && br) m_pc = int'(rs);
         else if (tk) begin
            off = im[8] ? int'(im) - 512 : int'(im);
            m_pc = (m_pc + 2 + off * 2 + 65536 * 2) % 65536;
         end else m_pc = (m_pc + 2) % 65536;
         if (we[2]) m_z = af[2];
         if (we[1]) m_v = af[1];
         if (we[0]) m_n = af[0];
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 3'd0, 9'h0, 16'h0, 3'd0, 3'd0);
   endtask

   task automatic jump(input logic [15:0] t);
      step(0, 0, 1, 1, 0, 3'd7, 9'h0, t, 3'd0, 3'd0);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, want %h at %0t", nm, act, req, $time);
   endtask

   // Monitor: compares each cycle's output just before the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               chk("pc", pc, e.pc);
               chk("pc_plus2", pc_plus2, e.pc2);
               chk("flags", {13'd0, flags}, {13'd0, e.flags});
               chk("halted", {15'd0, halted}, {15'd0, e.halted});
               chk("taken", {15'd0, taken}, {15'd0, e.taken});
            end
         end
      end
   end

   initial begin
      bit s, b, br, h, r;
      // 1: reset and sequential fetch
      step(1, 0, 0, 0, 0, 3'd0, 9'h0, 16'h0, 3'd0, 3'd0);
      repeat (5) idle();
      // 2: Z=1, B EQ backward, B NE not taken
      step(0, 0, 0, 0, 0, 3'd0, 9'h0, 16'h0, 3'b100, 3'b100);
      jump(16'h0010);
      step(0, 0, 1, 0, 0, 3'd1, 9'h1FE, 16'h0, 3'd0, 3'd0);
      jump(16'h0010);
      step(0, 0, 1, 0, 0, 3'd0, 9'h1FE, 16'h0, 3'd0, 3'd0);
      // 3: flag write and branch in the same cycle
      step(0, 0, 0, 0, 0, 3'd0, 9'h0, 16'h0, 3'b000, 3'b100);
      jump(16'h0020);
      step(0, 0, 1, 0, 0, 3'd1, 9'h010, 16'h0, 3'b100, 3'b100);
      step(0, 0, 1, 0, 0, 3'd1, 9'h010, 16'h0, 3'd0, 3'd0);
      // 4: BR with and without stall
      step(0, 1, 1, 1, 0, 3'd7, 9'h0, 16'h1234, 3'b111, 3'b111);
      step(0, 0, 1, 1, 0, 3'd7, 9'h0, 16'h1234, 3'd0, 3'd0);
      idle();
      // 5: halt, ignored inputs, reset out of halt
      jump(16'h0030);
      step(0, 0, 0, 0, 1, 3'd0, 9'h0, 16'h0, 3'd0, 3'd0);
      step(0, 0, 1, 1, 0, 3'd7, 9'h0, 16'h4444, 3'b111, 3'b111);
      step(0, 0, 1, 0, 0, 3'd7, 9'h020, 16'h0, 3'b010, 3'b010);
      step(1, 1, 0, 0, 0, 3'd0, 9'h0, 16'h0, 3'd0, 3'd0);
      idle();
      // 6: wraparound and max forward offset
      jump(16'hFFFE);
      idle();
      step(0, 0, 1, 0, 0, 3'd7, 9'h0FF, 16'h0, 3'd0, 3'd0);
      idle();
      // Random traffic
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 39) == 0);
         s  = ($urandom_range(0, 5) == 0);
         h  = ($urandom_range(0, 31) == 0);
         b  = !h && ($urandom_range(0, 2) == 0);
         br = b && ($urandom_range(0, 3) == 0);
         step(r, s, b, br, h, 3'($urandom), 9'($urandom), 16'($urandom & 32'hFFFE),
              3'($urandom), 3'($urandom));
      end
      idle();
      repeat (3) @(negedge clk);
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
